// File: rtl/ifetch.sv
// ifetch: instruction fetch stage wrapped around the instruction RAM.
// Generates the next fetch address and read enable, captures the
// 1-cycle-latency RAM response into a 2-entry {pc, inst} FIFO, and hands the
// head to decode over a valid/ready handshake. A redirect (jump_en_i) flushes
// the FIFO, drops any in-flight response and issues the target in the same
// cycle.
// Optional build macro IFETCH_BYPASS_EN: when the FIFO is empty, a returning
// response is presented to decode combinationally in its arrival cycle.
module ifetch #(
  parameter logic [31:0] RST_PC    = 32'h0800_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iram_rstn_i,
  output logic [31:0] pc_n_o,
  output logic        iram_rd_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  // ---------------------------------------------------------------- state
  logic [1:0]  r_count;                 // occupied FIFO entries (0..2)
  logic        r_head;                  // FIFO read index
  logic        r_pending;               // a RAM response is due this cycle
  logic        r_boot;                  // waiting for the RAM's reset fetch
  logic [31:0] r_fetch_pc;              // next sequential fetch address
  logic [31:0] r_pc_q   [BUF_DEPTH];
  logic [31:0] r_inst_q [BUF_DEPTH];

  // ---------------------------------------------------------------- wires
  logic [31:0] w_tgt;
  logic [31:0] w_pc_n;
  logic        w_push;
  logic        w_byp;
  logic        w_valid;
  logic        w_pop;
  logic        w_fpop;
  logic        w_wr;
  logic        w_widx;
  logic [2:0]  w_occ;
  logic        w_rd;
  logic        w_unused;

  // Low address bits are ignored: fetch is always word aligned.
  assign w_unused = ^jump_addr_i[1:0];
  assign w_tgt    = {jump_addr_i[31:2], 2'b00};

  // Until the RAM has done its own reset fetch, the address on the bus is
  // the reset PC; afterwards it is the sequential fetch pointer.
  assign w_pc_n = jump_en_i ? w_tgt : (r_boot ? RST_PC : r_fetch_pc);

  // A due response is captured unless a redirect kills it this cycle.
  assign w_push = r_pending & ~jump_en_i;

`ifdef IFETCH_BYPASS_EN
  assign w_byp = (r_count == 2'd0) & w_push;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid = (r_count != 2'd0) | w_byp;
  assign w_pop   = w_valid & id_ready_i;
  // Pop that actually removes a stored entry (a bypassed pop never stored).
  assign w_fpop  = w_pop & (r_count != 2'd0);
  // A bypassed response that decode takes immediately is not written.
  assign w_wr    = w_push & ~(w_byp & w_pop);
  assign w_widx  = r_head ^ r_count[0];

  // Entries that will be held or in flight after this cycle if we do not
  // issue; issuing is safe while that leaves room for one more.
  assign w_occ = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};

  // The RAM owns the bus during its reset fetch; a redirect always issues.
  assign w_rd = ~iram_rstn_i & (jump_en_i | (~r_boot & (w_occ < 3'd2)));

  assign pc_n_o     = w_pc_n;
  assign iram_rd_o  = w_rd;
  assign if_valid_o = w_valid;
  assign if_pc_o    = w_byp ? pc_i   : r_pc_q[r_head];
  assign if_inst_o  = w_byp ? inst_i : r_inst_q[r_head];

  // Fetch pointer, outstanding-response flag and boot tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RST_PC + 32'd4;
      r_pending  <= 1'b0;
      r_boot     <= 1'b1;
    end else begin
      // The RAM's reset-fetch cycle is an implicit issue of RST_PC unless a
      // redirect discards it.
      r_pending <= w_rd | (iram_rstn_i & ~jump_en_i);
      if (iram_rstn_i | jump_en_i)
        r_boot <= 1'b0;
      if (w_rd)
        r_fetch_pc <= w_pc_n + 32'd4;
      else if (iram_rstn_i)
        r_fetch_pc <= jump_en_i ? w_tgt : RST_PC + 32'd4;
    end
  end

  // FIFO occupancy and head pointer; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else if (jump_en_i) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_fpop};
      if (w_fpop)
        r_head <= ~r_head;
    end
  end

  // FIFO storage: write the captured response behind the occupied entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_pc_q[i]   <= 32'd0;
        r_inst_q[i] <= 32'd0;
      end
    end else if (w_wr) begin
      r_pc_q[w_widx]   <= pc_i;
      r_inst_q[w_widx] <= inst_i;
    end
  end

  // The issue rule must never let a response arrive into a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr && (r_count == 2'd2) && !w_fpop));

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset values, boot streaming, backpressure,
// redirect with a full buffer, redirect during the RAM reset fetch,
// back-to-back redirects and address wrap. A behavioural 1-cycle RAM returns
// inst = ~pc for every address.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0800_0000;
`ifdef IFETCH_BYPASS_EN
  localparam int D = 1;
`else
  localparam int D = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iram_rstn_i;
  logic [31:0] pc_n_o;
  logic        iram_rd_o;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] inst_i = 32'd0;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        if_valid_o;
  logic        id_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] h, h2;

  ifetch #(.RST_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .iram_rstn_i(iram_rstn_i),
    .pc_n_o(pc_n_o), .iram_rd_o(iram_rd_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;

  // Instruction RAM: 1-cycle read latency, reset fetch of RST_PC.
  always @(posedge clk) begin
    if (iram_rstn_i) begin
      pc_i   <= RST_PC;
      inst_i <= ~RST_PC;
    end else if (iram_rd_o) begin
      pc_i   <= pc_n_o;
      inst_i <= ~pc_n_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic hd(input string tag, input logic ev, input logic [31:0] epc);
    chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, ev});
    if (ev) begin
      chk({tag, ".pc"}, if_pc_o, epc);
      chk({tag, ".inst"}, if_inst_o, ~epc);
    end
  endtask

  task automatic step(input logic rn, input logic rdy, input logic jmp,
                      input logic [31:0] ja, input logic rstf);
    @(negedge clk);
    rst_n = rn; id_ready_i = rdy; jump_en_i = jmp; jump_addr_i = ja; iram_rstn_i = rstf;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, {31'd0, if_valid_o}, 32'd0);
    chk({tag, ".pc"}, if_pc_o, 32'd0);
    chk({tag, ".inst"}, if_inst_o, 32'd0);
    chk({tag, ".rd"}, {31'd0, iram_rd_o}, 32'd0);
    chk({tag, ".pc_n"}, pc_n_o, RST_PC);
  endtask

  initial begin
    rst_n = 1'b0; iram_rstn_i = 1'b0; id_ready_i = 1'b0;
    jump_en_i = 1'b0; jump_addr_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst0");

    // Boot: RST_PC first visible D cycles after release, then 1 per cycle.
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, c == 0);
      if (c == 0) begin
        chk("boot.rd0", {31'd0, iram_rd_o}, 32'd0);
        chk("boot.pcn0", pc_n_o, RST_PC);
      end
      if (c == 1) begin
        chk("boot.rd1", {31'd0, iram_rd_o}, 32'd1);
        chk("boot.pcn1", pc_n_o, RST_PC + 32'd4);
      end
      hd("boot", c >= D, RST_PC + 32'(4 * (c - D)));
    end

    // Backpressure: head held, issue stops once the buffer fills.
    h = RST_PC + 32'(4 * (10 - D));
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      hd("stall", 1'b1, h);
      if (c >= 1) chk("stall.rd", {31'd0, iram_rd_o}, 32'd0);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      if (c == 0) chk("resume.rd", {31'd0, iram_rd_o}, 32'd1);
      hd("resume", 1'b1, h + 32'(4 * c));
    end

    // Fill the buffer, then redirect to an unaligned target.
    h2 = h + 32'd20;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      hd("fill", 1'b1, h2);
    end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
    chk("jmp.pcn", pc_n_o, 32'h0000_0100);
    chk("jmp.rd", {31'd0, iram_rd_o}, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      hd("jmp", k >= D, 32'h0000_0100 + 32'(4 * (k - D)));
    end

    // Mid-run reset, then redirect during the RAM reset-fetch cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("rj.pcn0", pc_n_o, 32'h0000_0200);
    chk("rj.rd0", {31'd0, iram_rd_o}, 32'd0);
    hd("rj0", 1'b0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      if (c == 1) begin
        chk("rj.pcn1", pc_n_o, 32'h0000_0200);
        chk("rj.rd1", {31'd0, iram_rd_o}, 32'd1);
      end
      hd("rj", c >= D + 1, 32'h0000_0200 + 32'(4 * (c - D - 1)));
    end

    // Back-to-back redirects: only the newer target is delivered.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_reset("rst2");
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    hd("bb0", 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    chk("bb.pcn1", pc_n_o, 32'h0000_0300);
    hd("bb1", 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
    chk("bb.pcn2", pc_n_o, 32'h0000_0400);
    hd("bb2", 1'b0, 32'd0);
    for (int c = 3; c <= 8; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      hd("bb", c >= 2 + D, 32'h0000_0400 + 32'(4 * (c - 2 - D)));
    end

    // Fetch address wraps from 0xFFFF_FFFC to 0.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0);
    chk("wrap.pcn0", pc_n_o, 32'hFFFF_FFF8);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      if (k == 1) chk("wrap.pcn1", pc_n_o, 32'hFFFF_FFFC);
      if (k == 2) chk("wrap.pcn2", pc_n_o, 32'h0000_0000);
      hd("wrap", k >= D, 32'hFFFF_FFF8 + 32'(4 * (k - D)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
